// File: rtl/sensor_cfg_tx_if.sv
// Request handshake and radio-facing pins of the sensor configuration transmitter.
interface sensor_cfg_tx_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_reg;
  logic [15:0] req_data;
  logic        req_save;
  logic        done;
  logic        wireless_rx;
  logic        wireless_set;

  // Requester side: issues register writes and watches the line.
  modport master (
    output req_valid, req_reg, req_data, req_save,
    input  req_ready, done, wireless_rx, wireless_set
  );

  // Transmitter side.
  modport slave (
    input  req_valid, req_reg, req_data, req_save,
    output req_ready, done, wireless_rx, wireless_set
  );
endinterface

// File: rtl/sensor_cfg_tx.sv
// Writes one 16-bit sensor register over the wireless module's UART RX line
// as unlock / write / optional save frames of five 8N1 bytes each, with an
// idle-high gap after every frame.
module sensor_cfg_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int GAP_CLKS     = 4096
) (
  input  logic           clk_uart,
  input  logic           rst_n,
  sensor_cfg_tx_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int GAP_W = $clog2(GAP_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [1:0]       frame_q, frame_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       reg_q, reg_d;
  logic [15:0]      data_q, data_d;
  logic             save_q, save_d;
  logic             rx_q, rx_d;
  logic             done_s;
  logic             bit_end;
  logic [7:0]       cur_byte;

  // Byte idx of the given frame: unlock, write(reg, data LSB, data MSB), save.
  function automatic logic [7:0] frame_byte(input logic [1:0]  frame,
                                            input logic [2:0]  idx,
                                            input logic [7:0]  r,
                                            input logic [15:0] d);
    logic [7:0] b;
    b = 8'hFF;
    case (idx)
      3'd0: b = 8'hFF;
      3'd1: b = 8'hAA;
      3'd2: b = (frame == 2'd0) ? 8'h69 : (frame == 2'd1) ? r         : 8'h00;
      3'd3: b = (frame == 2'd0) ? 8'h88 : (frame == 2'd1) ? d[7:0]    : 8'h00;
      3'd4: b = (frame == 2'd0) ? 8'hB5 : (frame == 2'd1) ? d[15:8]   : 8'h00;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  // Sequencer next state, counters, request capture and next line level.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    frame_d  = frame_q;
    gap_d    = gap_q;
    reg_d    = reg_q;
    data_d   = data_q;
    save_d   = save_q;
    done_s   = 1'b0;
    bit_end  = (cnt_q == CNT_LAST);
    cur_byte = 8'hFF;
    rx_d     = 1'b1;

    case (state_q)
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        if (bit_end) begin
          if (byte_q == 3'd4) begin
            state_d = S_GAP;
            byte_d  = '0;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 3'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if ((frame_q == 2'd0) || ((frame_q == 2'd1) && save_q)) begin
            state_d = S_START;
            frame_d = frame_q + 2'd1;
          end else begin
            state_d = S_IDLE;
            frame_d = '0;
            done_s  = 1'b1;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: ;
    endcase

    // Acceptance is possible in IDLE and on the final gap cycle (done).
    if (bus.req_valid && ((state_q == S_IDLE) || done_s)) begin
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = '0;
      byte_d  = '0;
      frame_d = '0;
      gap_d   = '0;
      reg_d   = bus.req_reg;
      data_d  = bus.req_data;
      save_d  = bus.req_save;
    end

    cur_byte = frame_byte(frame_d, byte_d, reg_d, data_d);
    case (state_d)
      S_START: rx_d = 1'b0;
      S_DATA:  rx_d = cur_byte[bit_d];
      default: rx_d = 1'b1;
    endcase
  end

  // State, counters, latched request and the registered TX line.
  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      gap_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      save_q  <= 1'b0;
      rx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      frame_q <= frame_d;
      gap_q   <= gap_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      save_q  <= save_d;
      rx_q    <= rx_d;
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE) || done_s;
  assign bus.done         = done_s;
  assign bus.wireless_rx  = rx_q;
  assign bus.wireless_set = 1'b1;

endmodule

// File: tb/tb_sensor_cfg_tx.sv
// Bench for sensor_cfg_tx: request table plus hand-written corner sequences,
// with a UART decoder scoreboarding bytes, start cycles and done cycles.
module tb_sensor_cfg_tx;
  localparam int CPB = 4;
  localparam int GAP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sensor_cfg_tx_if bus();

  sensor_cfg_tx #(.CLKS_PER_BIT(CPB), .GAP_CLKS(GAP)) dut (
    .clk_uart (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [7:0] exp_byte_q[$];
  int         exp_start_q[$];
  int         exp_done_q[$];

  typedef struct {
    logic [7:0]  r;
    logic [15:0] d;
    logic        s;
    int          busy;
  } vec_t;
  vec_t vecs[4];

  // Expected line content and timing for a request accepted in cycle t.
  task automatic push_expect(input logic [7:0] r, input logic [15:0] d,
                             input logic s, input int busy, input int t);
    logic [7:0] seq[15];
    int n;
    seq = '{8'hFF, 8'hAA, 8'h69, 8'h88, 8'hB5,
            8'hFF, 8'hAA, r, d[7:0], d[15:8],
            8'hFF, 8'hAA, 8'h00, 8'h00, 8'h00};
    n = s ? 15 : 10;
    for (int j = 0; j < n; j++) begin
      exp_byte_q.push_back(seq[j]);
      exp_start_q.push_back(t + 1 + 10 * j * CPB + (j / 5) * GAP);
    end
    exp_done_q.push_back(t + busy);
  endtask

  // Called at a negedge; holds valid until accepted, returns accept cycle.
  task automatic send(input logic [7:0] r, input logic [15:0] d, input logic s,
                      input int busy, output int t);
    int n;
    bus.req_reg   = r;
    bus.req_data  = d;
    bus.req_save  = s;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("accept_timeout", 32'(bus.req_ready), 32'd1);
    t = cyc;
    push_expect(r, d, s, busy, t);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_reg   = ~r;
    bus.req_data  = ~d;
    bus.req_save  = ~s;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((exp_done_q.size() != 0 || exp_byte_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout_pending", 32'(exp_done_q.size() + exp_byte_q.size()), 32'd0);
  endtask

  // UART decoder and done monitor, sampling mid-bit on the falling edge.
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  int         m_start = 0;
  logic [7:0] m_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
    end else begin
      if (!m_busy) begin
        if (bus.wireless_rx == 1'b0) begin
          m_busy  = 1'b1;
          m_cnt   = 0;
          m_start = cyc;
        end
      end else begin
        m_cnt++;
      end
      if (m_busy && (m_cnt % CPB == CPB / 2)) begin
        int k;
        k = m_cnt / CPB;
        if (k == 0) begin
          check("start_bit", 32'(bus.wireless_rx), 32'd0);
        end else if (k <= 8) begin
          m_data[k-1] = bus.wireless_rx;
        end else begin
          check("stop_bit", 32'(bus.wireless_rx), 32'd1);
          m_busy = 1'b0;
          if (exp_byte_q.size() == 0) begin
            check("unexpected_byte", {24'd0, m_data}, 32'h100);
          end else begin
            check("byte", {24'd0, m_data}, {24'd0, exp_byte_q.pop_front()});
            check("start_cycle", 32'(m_start), 32'(exp_start_q.pop_front()));
          end
        end
      end
      if (bus.done) begin
        if (exp_done_q.size() == 0) check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        else check("done_cycle", 32'(cyc), 32'(exp_done_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, target;
    bus.req_valid = 1'b0;
    bus.req_reg   = '0;
    bus.req_data  = '0;
    bus.req_save  = 1'b0;

    vecs[0] = '{r: 8'h03, d: 16'h0006, s: 1'b1, busy: 624};
    vecs[1] = '{r: 8'h24, d: 16'hBEEF, s: 1'b0, busy: 416};
    vecs[2] = '{r: 8'hA5, d: 16'h1234, s: 1'b1, busy: 624};
    vecs[3] = '{r: 8'h00, d: 16'hFFFF, s: 1'b0, busy: 416};

    // Reset state, then release and confirm the line stays idle.
    repeat (3) @(negedge clk);
    check("rst_rx",    32'(bus.wireless_rx),  32'd1);
    check("rst_set",   32'(bus.wireless_set), 32'd1);
    check("rst_ready", 32'(bus.req_ready),    32'd1);
    check("rst_done",  32'(bus.done),         32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_rx",    32'(bus.wireless_rx),  32'd1);
    check("post_rst_set",   32'(bus.wireless_set), 32'd1);
    check("post_rst_ready", 32'(bus.req_ready),    32'd1);

    // Table of single requests.
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].r, vecs[i].d, vecs[i].s, vecs[i].busy, t);
      @(negedge clk);
      check("busy_ready", 32'(bus.req_ready), 32'd0);
      wait_idle(3000);
      check("idle_ready", 32'(bus.req_ready), 32'd1);
      repeat (3) @(negedge clk);
    end

    // Busy rejection: a mid-transfer request is neither accepted nor captured.
    send(8'h24, 16'hBEEF, 1'b1, 624, t);
    repeat (100) @(negedge clk);
    bus.req_reg   = 8'h55;
    bus.req_data  = 16'h5555;
    bus.req_save  = 1'b0;
    bus.req_valid = 1'b1;
    check("busy_reject_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wait_idle(3000);
    repeat (3) @(negedge clk);

    // Back-to-back: valid held across done, accepted on the done cycle.
    send(8'h11, 16'h2233, 1'b0, 416, t);
    send(8'h44, 16'h5566, 1'b1, 624, t2);
    check("b2b_accept_cycle", 32'(t2), 32'(t + 416));
    wait_idle(3000);
    repeat (3) @(negedge clk);

    // Asynchronous reset during data bit 3 of byte B5 (bit value 0).
    send(8'h77, 16'h8899, 1'b1, 624, t);
    target = t + 1 + 44 * CPB + CPB / 2;
    while (cyc < target) @(negedge clk);
    check("pre_reset_rx", 32'(bus.wireless_rx), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_rx",    32'(bus.wireless_rx), 32'd1);
    check("async_reset_done",  32'(bus.done),        32'd0);
    exp_byte_q.delete();
    exp_start_q.delete();
    exp_done_q.delete();
    repeat (3) @(negedge clk);
    check("in_reset_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    repeat (200 * CPB + 4 * GAP) @(negedge clk);
    check("after_abort_rx", 32'(bus.wireless_rx), 32'd1);
    send(8'h03, 16'h0006, 1'b1, 624, t);
    wait_idle(3000);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
